sc_backg_lane_datapath: RTL and testbench



---
 rtl/sc_backg_lane_datapath_pkg.sv | 12 +
 rtl/sc_backg_rate_counter.sv | 40 ++++
 rtl/sc_backg_lane_datapath.sv | 85 ++++++++
 tb/tb_sc_backg_lane_datapath.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sc_backg_lane_datapath_pkg.sv
// Shared constants for the background lane datapath and its controlling FSM.
package sc_backg_lane_datapath_pkg;

    localparam int unsigned SEL_WIDTH   = 2;
    localparam int unsigned LEVEL_WIDTH = 2;

    localparam logic [SEL_WIDTH-1:0] SEL_CLEAR  = 2'b00;
    localparam logic [SEL_WIDTH-1:0] SEL_LOAD   = 2'b01;
    localparam logic [SEL_WIDTH-1:0] SEL_ROTATE = 2'b10;
    localparam logic [SEL_WIDTH-1:0] SEL_HOLD   = 2'b11;

endpackage

// File: rtl/sc_backg_rate_counter.sv
// Speed counter: counts upcount strobes up to a level-scaled limit and raises
// an active-low move request that persists until the next clear.
module sc_backg_rate_counter
    import sc_backg_lane_datapath_pkg::*;
#(
    parameter int unsigned           COUNTWIDTH  = 24,
    parameter logic [COUNTWIDTH-1:0] COUNT_LIMIT = 24'd12_500_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   upcount_n,
    input  logic [LEVEL_WIDTH-1:0] level,
    output logic                   movement_n_c
);

    logic [COUNTWIDTH-1:0] count;
    logic [COUNTWIDTH-1:0] eff_shift_c;
    logic [COUNTWIDTH-1:0] eff_c;

    // Higher levels divide the period; never let the limit collapse to zero.
    always_comb begin
        eff_shift_c = COUNT_LIMIT >> level;
        eff_c       = (eff_shift_c == '0) ? COUNTWIDTH'(1) : eff_shift_c;
    end

    // Saturating count; clear wins over the upcount strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!upcount_n && (count < eff_c)) begin
            count <= count + COUNTWIDTH'(1);
        end
    end

    assign movement_n_c = (count < eff_c);

endmodule

// File: rtl/sc_backg_lane_datapath.sv
// Background lane datapath: holds and rotates one lane's obstacle pattern and
// returns the speed-counter move request to the background FSM.
module sc_backg_lane_datapath
    import sc_backg_lane_datapath_pkg::*;
#(
    parameter int unsigned                 ROTW         = 3,
    parameter int unsigned                 COUNTWIDTH   = 24,
    parameter logic [COUNTWIDTH-1:0]       COUNT_LIMIT  = 24'd12_500_000,
    parameter logic [(2**ROTW)-1:0]        INIT_PATTERN = 8'b1100_0110,
    parameter bit                          DIRECTION    = 1'b0
) (
    input  logic                       SC_BACKGLANE_CLOCK_50,
    input  logic                       SC_BACKGLANE_RESET_InLow,
    input  logic [SEL_WIDTH-1:0]       SC_BACKGLANE_shiftselection_InBus,
    input  logic                       SC_BACKGLANE_upcount_InLow,
    input  logic [LEVEL_WIDTH-1:0]     SC_BACKGLANE_level_InBus,
    input  logic [(2**ROTW)-1:0]       SC_BACKGLANE_data_InBus,
    output logic [(2**ROTW)-1:0]       SC_BACKGLANE_data_OutBus,
    output logic                       SC_BACKGLANE_movement_OutLow,
    output logic [ROTW-1:0]            SC_BACKGLANE_rotidx_OutBus,
    output logic                       SC_BACKGLANE_wrap_OutHigh
);

    localparam int unsigned DATAWIDTH = 2**ROTW;

    logic                 clk;
    logic                 rst_n;
    logic [SEL_WIDTH-1:0] sel;
    logic [DATAWIDTH-1:0] rotated_c;

    assign clk   = SC_BACKGLANE_CLOCK_50;
    assign rst_n = SC_BACKGLANE_RESET_InLow;
    assign sel   = SC_BACKGLANE_shiftselection_InBus;

    // Left rotation moves the MSB into bit 0; right rotation the reverse.
    always_comb begin
        if (DIRECTION) begin
            rotated_c = {SC_BACKGLANE_data_OutBus[0], SC_BACKGLANE_data_OutBus[DATAWIDTH-1:1]};
        end else begin
            rotated_c = {SC_BACKGLANE_data_OutBus[DATAWIDTH-2:0], SC_BACKGLANE_data_OutBus[DATAWIDTH-1]};
        end
    end

    // Pattern, rotation phase and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SC_BACKGLANE_data_OutBus   <= INIT_PATTERN;
            SC_BACKGLANE_rotidx_OutBus <= '0;
            SC_BACKGLANE_wrap_OutHigh  <= 1'b0;
        end else begin
            SC_BACKGLANE_wrap_OutHigh <= 1'b0;
            case (sel)
                SEL_CLEAR: begin
                    SC_BACKGLANE_data_OutBus   <= '0;
                    SC_BACKGLANE_rotidx_OutBus <= '0;
                end
                SEL_LOAD: begin
                    SC_BACKGLANE_data_OutBus   <= SC_BACKGLANE_data_InBus;
                    SC_BACKGLANE_rotidx_OutBus <= '0;
                end
                SEL_ROTATE: begin
                    SC_BACKGLANE_data_OutBus   <= rotated_c;
                    SC_BACKGLANE_rotidx_OutBus <= SC_BACKGLANE_rotidx_OutBus + ROTW'(1);
                    SC_BACKGLANE_wrap_OutHigh  <= (SC_BACKGLANE_rotidx_OutBus == ROTW'(DATAWIDTH-1));
                end
                default: begin
                end
            endcase
        end
    end

    // Any command other than hold consumes (or discards) the pending move.
    sc_backg_rate_counter #(
        .COUNTWIDTH  (COUNTWIDTH),
        .COUNT_LIMIT (COUNT_LIMIT)
    ) u_rate_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (sel != SEL_HOLD),
        .upcount_n    (SC_BACKGLANE_upcount_InLow),
        .level        (SC_BACKGLANE_level_InBus),
        .movement_n_c (SC_BACKGLANE_movement_OutLow)
    );

endmodule

// File: tb/tb_sc_backg_lane_datapath.sv
// Self-checking bench: directed scenarios plus randomized commands against a
// behavioural lane model.
module tb_sc_backg_lane_datapath;

    localparam int LIMIT = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic       up_n;
    logic [1:0] level;
    logic [7:0] din;
    logic [7:0] dout;
    logic       mov_n;
    logic [2:0] rotidx;
    logic       wrap;

    int vectors;
    int miscompares;

    // Reference model state
    int m_pat;
    int m_idx;
    int m_wrap;
    int m_cnt;

    sc_backg_lane_datapath #(
        .COUNT_LIMIT (24'd4)
    ) dut (
        .SC_BACKGLANE_CLOCK_50             (clk),
        .SC_BACKGLANE_RESET_InLow          (rst_n),
        .SC_BACKGLANE_shiftselection_InBus (sel),
        .SC_BACKGLANE_upcount_InLow        (up_n),
        .SC_BACKGLANE_level_InBus          (level),
        .SC_BACKGLANE_data_InBus           (din),
        .SC_BACKGLANE_data_OutBus          (dout),
        .SC_BACKGLANE_movement_OutLow      (mov_n),
        .SC_BACKGLANE_rotidx_OutBus        (rotidx),
        .SC_BACKGLANE_wrap_OutHigh         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    function automatic int eff_of(input int lvl);
        int e;
        e = LIMIT / (1 << lvl);
        if (e == 0) e = 1;
        return e;
    endfunction

    task automatic m_reset();
        m_pat  = 'hC6;
        m_idx  = 0;
        m_wrap = 0;
        m_cnt  = 0;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".data"},   int'(dout),   m_pat);
        check_val({tag, ".mov"},    int'(mov_n),  (m_cnt >= eff_of(int'(level))) ? 0 : 1);
        check_val({tag, ".rotidx"}, int'(rotidx), m_idx);
        check_val({tag, ".wrap"},   int'(wrap),   m_wrap);
        check_val({tag, ".count"},  int'(dut.u_rate_counter.count), m_cnt);
    endtask

    // Apply one cycle of inputs, advance the model on the same edge, then compare.
    task automatic step(input int s, input int u, input int l, input int d, input string tag);
        int e;
        sel   = 2'(s);
        up_n  = 1'(u);
        level = 2'(l);
        din   = 8'(d);
        @(posedge clk);
        e = eff_of(l);
        if (s != 3) m_cnt = 0;
        else if (u == 0 && m_cnt < e) m_cnt = m_cnt + 1;
        m_wrap = 0;
        case (s)
            0: begin m_pat = 0; m_idx = 0; end
            1: begin m_pat = d; m_idx = 0; end
            2: begin
                m_pat  = ((m_pat * 2) % 256) + (m_pat / 128);
                m_wrap = (m_idx == 7) ? 1 : 0;
                m_idx  = (m_idx + 1) % 8;
            end
            default: ;
        endcase
        #1;
        check_all(tag);
    endtask

    initial begin
        int s, r;
        vectors     = 0;
        miscompares = 0;
        sel   = 2'b11;
        up_n  = 1'b1;
        level = 2'd0;
        din   = 8'h00;
        rst_n = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Four strobes reach the limit; further strobes saturate.
        for (int i = 0; i < 4; i++) step(3, 0, 0, 0, "strobe");
        check_val("mov_after4", int'(mov_n), 0);
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0, "sat");
        check_val("count_sat", int'(dut.u_rate_counter.count), 4);

        // Consuming the move rotates the lane and rearms the counter.
        step(2, 1, 0, 0, "rot1");
        check_val("rot1_data", int'(dout), 'h8D);
        check_val("rot1_mov", int'(mov_n), 1);
        step(3, 1, 0, 0, "rot1_idle");
        check_val("rot1_idle_mov", int'(mov_n), 1);

        for (int i = 0; i < 7; i++) step(2, 1, 0, 0, "rot");
        check_val("wrap_after8", int'(wrap), 1);
        check_val("data_after8", int'(dout), 'hC6);
        step(3, 1, 0, 0, "post_wrap");
        check_val("wrap_cleared", int'(wrap), 0);

        // Level raised mid-count takes effect without a clock edge.
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0, "cnt3");
        level = 2'd1;
        #1;
        check_val("lvl1_mov_now", int'(mov_n), 0);
        step(3, 0, 1, 0, "lvl1_hold");
        check_val("lvl1_count_held", int'(dut.u_rate_counter.count), 3);
        level = 2'd3;
        #1;
        check_val("lvl3_mov_clamp", int'(mov_n), 0);
        step(3, 1, 3, 0, "lvl3");

        // Load discards the pending count.
        step(1, 1, 0, 'hF0, "load");
        check_val("load_data", int'(dout), 'hF0);
        for (int i = 0; i < 3; i++) step(3, 0, 0, 0, "cnt_pre_load");
        step(1, 0, 0, 'h3C, "load2");
        check_val("load2_count", int'(dut.u_rate_counter.count), 0);

        // Async reset drops a pending move immediately.
        for (int i = 0; i < 4; i++) step(3, 0, 0, 0, "pend");
        check_val("pend_mov", int'(mov_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_val("async_mov", int'(mov_n), 1);
        check_all("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized commands, mostly holds so moves can build up.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) s = 0;
            else if (r == 1) s = 1;
            else if (r <= 3) s = 2;
            else s = 3;
            step(s, int'($urandom_range(0, 3) != 0 ? 0 : 1),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : int'(level),
                 int'($urandom_range(0, 255)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
